// File: rtl/serial_adder_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial WIDTH-bit adder built around one full-adder cell
//               and a carry flop. Operands a/b/ci are captured in a single
//               transfer and rippled LSB-first, one bit per clock; the result
//               is then held on sum/co until the consumer takes it.
// Ports       : clk       in   rising-edge clock
//               rst_n     in   asynchronous active-low reset
//               in_valid  in   operands a/b/ci valid
//               in_ready  out  block can accept operands (state is IDLE)
//               a, b      in   WIDTH-bit operands
//               ci        in   carry-in to bit 0
//               out_valid out  sum/co valid
//               out_ready in   consumer accepts result
//               sum       out  (a+b+ci) mod 2^WIDTH
//               co        out  carry-out of bit WIDTH-1
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_co;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  // The single full-adder cell, fed from the low bits of the operand shifters.
  logic w_s;
  logic w_carry_nxt;

  assign w_s         = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry_nxt = (r_a_sh[0] & r_b_sh[0]) | ((r_a_sh[0] ^ r_b_sh[0]) & r_carry);

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign co        = r_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_co        <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= ci;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Each sum bit enters at the MSB; after WIDTH shifts bit 0 of the
          // result has walked down to bit 0.
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_carry_nxt;
          if (r_cnt == C_LAST_BIT) begin
            // Counter is left at its final value so it can never wrap.
            r_co        <= w_carry_nxt;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl. Directed vectors
//               with hand-computed results on a WIDTH=8 instance, plus an
//               exhaustive operand sweep with random output stalls on a
//               WIDTH=4 instance.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ci = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       co;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       ci4 = 1'b0;
  logic       out_valid4;
  logic       out_ready4 = 1'b0;
  logic [3:0] sum4;
  logic       co4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .ci        (ci4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .co        (co4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for out_valid on the 8-bit instance; returns cycles taken.
  task automatic wait_out8(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      seen = out_valid;
    end
    check("out_valid_seen", 64'(seen), 64'd1);
  endtask

  // One complete operation on the 8-bit instance. Phase on entry/exit: 1ns
  // after a rising edge.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                        input logic [7:0] esum, input logic eco,
                        input int stall, input bit early_ready);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_in_ready", 64'(in_ready), 64'd1);
    a = ta; b = tb_v; ci = tci; in_valid = 1'b1;
    out_ready = early_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
    check("run_in_ready", 64'(in_ready), 64'd0);
    check("run_out_valid", 64'(out_valid), 64'd0);
    wait_out8(k);
    check("latency", 64'(k), 64'd8);
    check("sum", 64'(sum), 64'(esum));
    check("co", 64'(co), 64'(eco));
    check("done_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_sum", 64'(sum), 64'(esum));
      check("stall_co", 64'(co), 64'(eco));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit seen;
    int exp;
    int nstall;

    // Reset state, asserted from time zero.
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", 64'(co), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b1);  // out_ready high throughout RUN
    run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 0, 1'b0);
    // Backpressure: five stalled cycles in DONE.
    run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 5, 1'b0);

    // in_valid held with new operands during RUN and DONE.
    a = 8'h5A; b = 8'h3C; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; ci = 1'b0;
    @(posedge clk); #1;
    check("hold_run_in_ready", 64'(in_ready), 64'd0);
    wait_out8(k);
    check("hold_latency", 64'(k), 64'd7);
    check("hold_sum", 64'(sum), 64'h96);
    check("hold_co", 64'(co), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;   // new operands captured here
    in_valid = 1'b0; a = '0; b = '0;
    check("hold_second_run", 64'(in_ready), 64'd0);
    wait_out8(k);
    check("hold2_latency", 64'(k), 64'd8);
    check("hold2_sum", 64'(sum), 64'h33);
    check("hold2_co", 64'(co), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during RUN cycle 3, between clock edges.
    a = 8'hFF; b = 8'hFF; ci = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_run_out_valid", 64'(out_valid), 64'd0);
    check("arst_run_in_ready", 64'(in_ready), 64'd1);
    check("arst_run_sum", 64'(sum), 64'd0);
    check("arst_run_co", 64'(co), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("arst_run_no_pulse", 64'(seen), 64'd0);
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0);

    // Reset while holding a result in DONE.
    a = 8'hFF; b = 8'h01; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out8(k);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_done_out_valid", 64'(out_valid), 64'd0);
    check("arst_done_in_ready", 64'(in_ready), 64'd1);
    check("arst_done_sum", 64'(sum), 64'd0);
    check("arst_done_co", 64'(co), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1, 1'b0);

    // Exhaustive 4-bit sweep with random output stalls.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          k = 0;
          while (!in_ready4 && k < 20) begin
            @(posedge clk); #1;
            k++;
          end
          a4 = 4'(ia); b4 = 4'(ib); ci4 = 1'(ic); in_valid4 = 1'b1;
          @(posedge clk); #1;
          in_valid4 = 1'b0;
          seen = 1'b0;
          k = 0;
          while (!seen && k < 20) begin
            @(posedge clk); #1;
            k++;
            seen = out_valid4;
          end
          exp = ia + ib + ic;
          if (!seen) check("w4_timeout", 64'(seen), 64'd1);
          check($sformatf("w4_%0h_%0h_%0d", ia, ib, ic), 64'({co4, sum4}), 64'(exp));
          nstall = int'($urandom_range(0, 3));
          repeat (nstall) begin
            @(posedge clk); #1;
          end
          out_ready4 = 1'b1;
          @(posedge clk); #1;
          out_ready4 = 1'b0;
        end
      end
    end
    check("w4_final_in_ready", 64'(in_ready4), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
